univ_shift_reg: RTL and testbench
=================================

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: register width in bits (legal range 2..64).
REQ-002 The block SHALL have parameter CNT_W, default 5: width of the burst count; 2^CNT_W-1 >= WIDTH.
REQ-003 The block SHALL have port clk  in  1  single clock, rising edge.
REQ-004 The block SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-005 The block SHALL have port en  in  1  clock enable; low = freeze all state (Q, counter, busy), done forced 0.
REQ-006 The block SHALL have port mode  in  3  operation select, sampled on en-qualified edges.
REQ-007 The block SHALL have port s_in_r  in  1  serial input entering bit WIDTH-1 on right shifts.
REQ-008 The block SHALL have port s_in_l  in  1  serial input entering bit 0 on left shifts.
REQ-009 The block SHALL have port p_in  in  WIDTH  parallel load data.
REQ-010 The block SHALL have port nshift  in  CNT_W  burst shift count, sampled at burst start.
REQ-011 The block SHALL have port Q  out  WIDTH  register contents.
REQ-012 The block SHALL have port s_out_r  out  1  equals Q[0].
REQ-013 The block SHALL have port s_out_l  out  1  equals Q[WIDTH-1].
REQ-014 The block SHALL have port busy  out  1  burst in progress.
REQ-015 The block SHALL have port done  out  1  one-cycle pulse at burst completion.

Function
REQ-016 When idle and en=1, the block SHALL decode mode per edge: 000 hold; 001 shr Q<={s_in_r,Q[W-1:1]}; 010 shl Q<={Q[W-2:0],s_in_l}; 011 rotr Q<={Q[0],Q[W-1:1]}; 100 rotl Q<={Q[W-2:0],Q[W-1]}; 101 load Q<=p_in; 110 burst start; 111 clear Q<=0.
REQ-017 All mode effects SHALL appear on Q at the first rising edge after sampling (latency 1); s_out_r/s_out_l SHALL be combinational from Q.
REQ-018 The controller SHALL have two states, IDLE and BURST; reset state IDLE.
REQ-019 IDLE->BURST SHALL occur on an en-qualified edge with mode=110 and nshift!=0: cnt<=nshift, busy<=1, Q unchanged on that edge.
REQ-020 mode=110 with nshift=0 SHALL stay IDLE, leave Q unchanged and assert done for the following cycle.
REQ-021 In BURST, each en-qualified edge SHALL perform one shr (s_in_r sampled that edge) and decrement cnt.
REQ-022 BURST->IDLE SHALL occur on the edge where cnt goes 1->0; busy deasserts and done asserts for exactly one cycle on that same edge.
REQ-023 In BURST, mode SHALL be ignored except 111, which aborts: Q<=0, cnt<=0, busy<=0, done not asserted.
REQ-024 nshift greater than WIDTH SHALL be honoured literally (extra shifts continue filling from s_in_r).
REQ-025 en=0 during BURST SHALL pause the burst with cnt, Q and busy held; done SHALL never be high while en=0.
REQ-026 A new burst SHALL be accepted on the cycle immediately after done (back-to-back bursts, no dead cycle required).

Reset
REQ-027 rst_n=0 SHALL asynchronously force Q=0, cnt=0, state=IDLE, busy=0, done=0, independent of clk and en.
REQ-028 Reset asserted mid-burst SHALL abort the burst with no done pulse; the first edge after rst_n rises SHALL be a normal IDLE decode.
REQ-029 Reset deassertion SHALL be synchronous to clk externally; the block SHALL need no internal synchroniser.

Verification
REQ-030 WIDTH=16: load p_in=16'hA5C3, then 4x rotr -> Q=16'h3A5C; then 4x rotl -> Q=16'hA5C3.
REQ-031 Q=16'h8001, shr with s_in_r=1 -> Q=16'hC000, s_out_r=0; shl with s_in_l=1 -> Q=16'h8001.
REQ-032 Q=16'hFFFF, burst nshift=5, s_in_r=0 -> busy high 5 cycles, Q=16'h07FF, done single pulse coincident with busy falling.
REQ-033 Burst nshift=6 with en low for 3 cycles mid-burst -> busy high 9 cycles total, Q frozen during pause, one done pulse.
REQ-034 Burst nshift=0 -> busy never asserts, Q unchanged, done high for one cycle; burst nshift=8 with mode=111 on third cycle -> Q=0, busy=0, no done.
REQ-035 rst_n pulsed low between edges mid-burst -> Q=0, busy=0, done=0 immediately; next burst nshift=3 completes normally.

Source files
------------

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right/left, rotate right/left,
// parallel load, clear, and a counted right-shift burst with busy/done.
module univ_shift_reg #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             s_in_r,
  input  logic             s_in_l,
  input  logic [WIDTH-1:0] p_in,
  input  logic [CNT_W-1:0] nshift,
  output logic [WIDTH-1:0] Q,
  output logic             s_out_r,
  output logic             s_out_l,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    OP_HOLD  = 3'b000,
    OP_SHR   = 3'b001,
    OP_SHL   = 3'b010,
    OP_ROTR  = 3'b011,
    OP_ROTL  = 3'b100,
    OP_LOAD  = 3'b101,
    OP_BURST = 3'b110,
    OP_CLEAR = 3'b111
  } op_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  op_t              w_op;

  assign w_op = op_t'(mode);

  // Register, burst counter and controller; en low freezes everything except
  // the done flag, which is cleared so it cannot reappear when en returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_q     <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (!en) begin
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          case (w_op)
            OP_HOLD:  r_q <= r_q;
            OP_SHR:   r_q <= {s_in_r, r_q[WIDTH-1:1]};
            OP_SHL:   r_q <= {r_q[WIDTH-2:0], s_in_l};
            OP_ROTR:  r_q <= {r_q[0], r_q[WIDTH-1:1]};
            OP_ROTL:  r_q <= {r_q[WIDTH-2:0], r_q[WIDTH-1]};
            OP_LOAD:  r_q <= p_in;
            OP_BURST: begin
              if (nshift != '0) begin
                r_cnt   <= nshift;
                r_busy  <= 1'b1;
                r_state <= BURST;
              end else begin
                r_done  <= 1'b1;
              end
            end
            OP_CLEAR: r_q <= '0;
            default:  r_q <= r_q;
          endcase
        end
        BURST: begin
          if (w_op == OP_CLEAR) begin
            r_q     <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_q   <= {s_in_r, r_q[WIDTH-1:1]};
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CNT_W'(1)) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Outputs: serial taps straight from Q; done gated so it is never seen with en low.
  always_comb begin
    Q       = r_q;
    s_out_r = r_q[0];
    s_out_l = r_q[WIDTH-1];
    busy    = r_busy;
    done    = r_done & en;
  end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=16, CNT_W=5).
module tb_univ_shift_reg;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [2:0]  mode;
  logic        s_in_r;
  logic        s_in_l;
  logic [15:0] p_in;
  logic [4:0]  nshift;
  logic [15:0] Q;
  logic        s_out_r;
  logic        s_out_l;
  logic        busy;
  logic        done;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  logic [15:0] m_q;
  int          m_rem;
  logic        m_done;

  int busy_cnt;
  int done_cnt;

  univ_shift_reg #(.WIDTH(16), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .s_in_r(s_in_r), .s_in_l(s_in_l), .p_in(p_in), .nshift(nshift),
    .Q(Q), .s_out_r(s_out_r), .s_out_l(s_out_l), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".Q"},     64'(Q),       64'(m_q));
    chk({tag, ".busy"},  64'(busy),    64'(m_rem > 0));
    chk({tag, ".done"},  64'(done),    64'(m_done & en));
    chk({tag, ".sor"},   64'(s_out_r), 64'(m_q % 2));
    chk({tag, ".sol"},   64'(s_out_l), 64'(m_q / 16'h8000));
  endtask

  // One clock: drive inputs, take the edge, advance the model, compare.
  task automatic cyc(input string tag, input logic e, input logic [2:0] m,
                     input logic sr, input logic sl, input logic [15:0] p,
                     input logic [4:0] ns);
    en = e; mode = m; s_in_r = sr; s_in_l = sl; p_in = p; nshift = ns;
    @(posedge clk);
    #1;
    if (!e) begin
      m_done = 1'b0;
    end else if (m_rem > 0) begin
      m_done = 1'b0;
      if (m == 3'd7) begin
        m_q = 16'h0; m_rem = 0;
      end else begin
        m_q = (m_q >> 1) + (sr ? 16'h8000 : 16'h0);
        m_rem = m_rem - 1;
        m_done = (m_rem == 0);
      end
    end else begin
      m_done = 1'b0;
      case (m)
        3'd1: m_q = (m_q >> 1) + (sr ? 16'h8000 : 16'h0);
        3'd2: m_q = (m_q << 1) + 16'(sl);
        3'd3: m_q = (m_q >> 1) + ((m_q % 2) ? 16'h8000 : 16'h0);
        3'd4: m_q = (m_q << 1) + (m_q / 16'h8000);
        3'd5: m_q = p;
        3'd6: if (ns == 0) m_done = 1'b1; else m_rem = int'(ns);
        3'd7: m_q = 16'h0;
        default: ;
      endcase
    end
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    chk_all(tag);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 3'd0; s_in_r = 1'b0; s_in_l = 1'b0;
    p_in = 16'h0; nshift = 5'd0;
    m_q = 16'h0; m_rem = 0; m_done = 1'b0;
    busy_cnt = 0; done_cnt = 0;

    repeat (2) @(posedge clk);
    #1;
    chk_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Load and rotations
    cyc("load", 1, 3'd5, 0, 0, 16'hA5C3, 0);
    chk("load.val", 64'(Q), 64'h A5C3);
    repeat (4) cyc("rotr", 1, 3'd3, 0, 0, 0, 0);
    chk("rotr4", 64'(Q), 64'h3A5C);
    repeat (4) cyc("rotl", 1, 3'd4, 0, 0, 0, 0);
    chk("rotl4", 64'(Q), 64'hA5C3);

    // Serial shifts at the boundaries
    cyc("ld8001", 1, 3'd5, 0, 0, 16'h8001, 0);
    cyc("shr", 1, 3'd1, 1, 0, 0, 0);
    chk("shr.val", 64'(Q), 64'hC000);
    chk("shr.sor", 64'(s_out_r), 64'd0);
    cyc("shl", 1, 3'd2, 0, 1, 0, 0);
    chk("shl.val", 64'(Q), 64'h8001);
    cyc("hold", 1, 3'd0, 1, 1, 16'h1234, 0);

    // Burst of 5 from all-ones
    cyc("ldFFFF", 1, 3'd5, 0, 0, 16'hFFFF, 0);
    busy_cnt = 0; done_cnt = 0;
    cyc("b5.start", 1, 3'd6, 0, 0, 0, 5'd5);
    repeat (5) cyc("b5", 1, 3'd0, 0, 0, 0, 0);
    chk("b5.Q", 64'(Q), 64'h07FF);
    chk("b5.busycyc", 64'(busy_cnt), 64'd5);
    chk("b5.donecnt", 64'(done_cnt), 64'd1);
    cyc("b5.after", 1, 3'd0, 0, 0, 0, 0);

    // Burst of 6 with a 3-cycle pause
    busy_cnt = 0; done_cnt = 0;
    cyc("b6.start", 1, 3'd6, 0, 0, 0, 5'd6);
    repeat (2) cyc("b6.a", 1, 3'd5, 1, 0, 16'h5555, 0);
    repeat (3) cyc("b6.pause", 0, 3'd7, 0, 0, 0, 0);
    repeat (4) cyc("b6.b", 1, 3'd2, 1, 0, 0, 0);
    chk("b6.busycyc", 64'(busy_cnt), 64'd9);
    chk("b6.donecnt", 64'(done_cnt), 64'd1);

    // Back-to-back burst, then nshift=0
    cyc("b2.start", 1, 3'd6, 0, 0, 0, 5'd2);
    cyc("b2.a", 1, 3'd0, 0, 0, 0, 0);
    cyc("b2.b", 1, 3'd0, 1, 0, 0, 0);
    cyc("b2b.start", 1, 3'd6, 0, 0, 0, 5'd1);
    cyc("b2b.a", 1, 3'd0, 1, 0, 0, 0);
    chk("b2b.done", 64'(done), 64'd1);
    cyc("ld", 1, 3'd5, 0, 0, 16'h1F2E, 0);
    cyc("b0", 1, 3'd6, 1, 1, 0, 5'd0);
    chk("b0.done", 64'(done), 64'd1);
    chk("b0.Q", 64'(Q), 64'h1F2E);
    cyc("b0.after", 1, 3'd0, 0, 0, 0, 0);

    // Abort with clear on third burst cycle
    cyc("b8.start", 1, 3'd6, 1, 0, 0, 5'd8);
    cyc("b8.a", 1, 3'd0, 1, 0, 0, 0);
    cyc("b8.abort", 1, 3'd7, 1, 0, 0, 0);
    chk("abort.Q", 64'(Q), 64'h0);
    chk("abort.busy", 64'(busy), 64'd0);
    chk("abort.done", 64'(done), 64'd0);
    cyc("abort.after", 1, 3'd0, 0, 0, 0, 0);

    // Asynchronous reset between edges during a burst
    cyc("ld", 1, 3'd5, 0, 0, 16'hBEEF, 0);
    cyc("r.start", 1, 3'd6, 0, 0, 0, 5'd10);
    cyc("r.a", 1, 3'd0, 1, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    m_q = 16'h0; m_rem = 0; m_done = 1'b0;
    chk("arst.Q", 64'(Q), 64'h0);
    chk("arst.busy", 64'(busy), 64'd0);
    chk("arst.done", 64'(done), 64'd0);
    #1 rst_n = 1'b1;
    cyc("ld", 1, 3'd5, 0, 0, 16'h00F0, 0);
    busy_cnt = 0; done_cnt = 0;
    cyc("b3.start", 1, 3'd6, 1, 0, 0, 5'd3);
    repeat (3) cyc("b3", 1, 3'd0, 1, 0, 0, 0);
    chk("b3.Q", 64'(Q), 64'hE01E);
    chk("b3.donecnt", 64'(done_cnt), 64'd1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc("rand", ($urandom_range(0, 7) != 0), 3'($urandom_range(0, 7)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          16'($urandom), 5'($urandom_range(0, 20)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
